// File: rtl/l2_req_sched.sv
// Credit-limited L2 request scheduler: slot allocation, tagged issue, per-id completion.
// Optional macro L2_REQ_SCHED_DUP_FILTER_EN merges requests for ids already in flight.
module l2_req_sched #(
  parameter int unsigned NCL   = 16,
  parameter int unsigned CLW   = 4,
  parameter int unsigned NSLOT = 4,
  parameter int unsigned TW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_v,
  output logic           i_r,
  input  logic [CLW-1:0] i_clid,
  output logic           o_v,
  input  logic           o_r,
  output logic [CLW-1:0] o_clid,
  output logic [TW-1:0]  o_tag,
  input  logic           i_rsp_v,
  input  logic [TW-1:0]  i_rsp_tag,
  output logic           o_done_v,
  output logic [CLW-1:0] o_done_clid,
  output logic [NCL-1:0] o_busy,
  output logic [TW:0]    o_outst,
  output logic           o_err
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e           state_q, state_d;
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [CLW-1:0]   clid_q [NSLOT];
  logic [CLW-1:0]   o_clid_q, done_clid_q;
  logic [TW-1:0]    o_tag_q;
  logic             done_v_q, err_q;

  logic             rsp_valid, rsp_hit, free_any, can_take, accept, issue;
  logic [CLW-1:0]   rsp_clid;
  logic [TW-1:0]    alloc_idx;
`ifdef L2_REQ_SCHED_DUP_FILTER_EN
  logic             dup;
`endif

  always_comb begin
    rsp_valid = i_rsp_v && valid_q[i_rsp_tag];
    rsp_clid  = clid_q[i_rsp_tag];
    rsp_hit   = rsp_valid && (rsp_clid == i_clid);
    // Search uses pre-response state, so a slot freed this cycle is never reallocated.
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_any  = 1'b1;
        alloc_idx = TW'(k);
      end
    end
`ifdef L2_REQ_SCHED_DUP_FILTER_EN
    dup = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (valid_q[k] && (clid_q[k] == i_clid) && !(rsp_valid && (i_rsp_tag == TW'(k)))) begin
        dup = 1'b1;
      end
    end
    can_take = free_any || dup;
`else
    can_take = free_any;
`endif
    i_r    = reset && ((state_q == StIdle) || o_r) && can_take && !rsp_hit;
    accept = i_v && i_r;
`ifdef L2_REQ_SCHED_DUP_FILTER_EN
    issue  = accept && !dup;
`else
    issue  = accept;
`endif
    valid_d = valid_q;
    if (rsp_valid) valid_d[i_rsp_tag] = 1'b0;
    if (issue)     valid_d[alloc_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StIssue;
      StIssue: if (o_r && !issue) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy  = '0;
    o_outst = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (valid_q[k]) o_busy[clid_q[k]] = 1'b1;
      o_outst = o_outst + (TW+1)'(valid_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      for (int k = 0; k < NSLOT; k++) clid_q[k] <= '0;
      o_clid_q    <= '0;
      o_tag_q     <= '0;
      done_v_q    <= 1'b0;
      done_clid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      done_v_q <= rsp_valid;
      err_q    <= err_q | (i_rsp_v && !valid_q[i_rsp_tag]);
      if (issue) begin
        clid_q[alloc_idx] <= i_clid;
        o_clid_q          <= i_clid;
        o_tag_q           <= alloc_idx;
      end
      if (rsp_valid) done_clid_q <= rsp_clid;
    end
  end

  assign o_v         = (state_q == StIssue);
  assign o_clid      = o_clid_q;
  assign o_tag       = o_tag_q;
  assign o_done_v    = done_v_q;
  assign o_done_clid = done_clid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_l2_req_sched.sv
// Directed self-checking bench for l2_req_sched; inputs driven and outputs sampled on negedge.
module tb_l2_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_v, i_r, o_v, o_r, i_rsp_v, o_done_v, o_err;
  logic [3:0]  i_clid, o_clid, o_done_clid;
  logic [1:0]  o_tag, i_rsp_tag;
  logic [15:0] o_busy;
  logic [2:0]  o_outst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_req_sched dut (
    .clk         (clk),
    .reset       (reset),
    .i_v         (i_v),
    .i_r         (i_r),
    .i_clid      (i_clid),
    .o_v         (o_v),
    .o_r         (o_r),
    .o_clid      (o_clid),
    .o_tag       (o_tag),
    .i_rsp_v     (i_rsp_v),
    .i_rsp_tag   (i_rsp_tag),
    .o_done_v    (o_done_v),
    .o_done_clid (o_done_clid),
    .o_busy      (o_busy),
    .o_outst     (o_outst),
    .o_err       (o_err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; i_v = 1'b0; i_clid = '0; o_r = 1'b0; i_rsp_v = 1'b0; i_rsp_tag = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; i_v = 1'b1; i_clid = 4'd5; o_r = 1'b0; i_rsp_v = 1'b0; i_rsp_tag = '0;
    step();
    n_checks++; if (i_r !== 1'b0) begin n_fail++; $display("FAIL rst_i_r got %b exp 0", i_r); end
    n_checks++; if ({o_v, o_clid, o_tag, o_done_v, o_done_clid, o_err} !== 12'h0) begin
      n_fail++; $display("FAIL rst_outs got %b/%h/%h/%b/%h/%b exp zeros",
                         o_v, o_clid, o_tag, o_done_v, o_done_clid, o_err); end
    n_checks++; if ({o_busy, o_outst} !== 19'h0) begin
      n_fail++; $display("FAIL rst_busy got %h/%0d exp 0/0", o_busy, o_outst); end
    reset = 1'b1;
    #1;
    n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL rel_i_r got %b exp 1", i_r); end
    step();
    i_v = 1'b0;
    n_checks++; if ({o_v, o_clid, o_tag} !== {1'b1, 4'd5, 2'd0}) begin
      n_fail++; $display("FAIL first_issue got v=%b clid=%0d tag=%0d exp 1/5/0", o_v, o_clid, o_tag); end
    n_checks++; if (o_busy !== 16'h0020 || o_outst !== 3'd1) begin
      n_fail++; $display("FAIL first_busy got %h/%0d exp 0020/1", o_busy, o_outst); end
  endtask

  task automatic test_fill();
    do_reset();
    o_r = 1'b1;
    for (int id = 0; id < 4; id++) begin
      i_v = 1'b1; i_clid = 4'(id);
      #1;
      n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL fill_i_r[%0d] got %b exp 1", id, i_r); end
      step();
      n_checks++; if ({o_v, o_clid, o_tag} !== {1'b1, 4'(id), 2'(id)}) begin
        n_fail++; $display("FAIL fill_issue[%0d] got %b/%0d/%0d exp 1/%0d/%0d",
                           id, o_v, o_clid, o_tag, id, id); end
    end
    i_clid = 4'd4;
    #1;
    n_checks++; if (i_r !== 1'b0 || o_outst !== 3'd4) begin
      n_fail++; $display("FAIL full got i_r=%b outst=%0d exp 0/4", i_r, o_outst); end
    n_checks++; if (o_busy !== 16'h000f) begin
      n_fail++; $display("FAIL full_busy got %h exp 000f", o_busy); end
    step();
    i_rsp_v = 1'b1; i_rsp_tag = 2'd2;
    #1;
    n_checks++; if (i_r !== 1'b0) begin n_fail++; $display("FAIL full_rsp_i_r got %b exp 0", i_r); end
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b1 || o_done_clid !== 4'd2 || o_outst !== 3'd3) begin
      n_fail++; $display("FAIL done2 got %b/%0d/%0d exp 1/2/3", o_done_v, o_done_clid, o_outst); end
    #1;
    n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL reopen_i_r got %b exp 1", i_r); end
    step();
    i_v = 1'b0;
    n_checks++; if ({o_v, o_clid, o_tag, o_done_v} !== {1'b1, 4'd4, 2'd2, 1'b0}) begin
      n_fail++; $display("FAIL reuse got %b/%0d/%0d/%b exp 1/4/2/0", o_v, o_clid, o_tag, o_done_v); end
    n_checks++; if (o_outst !== 3'd4 || o_busy !== 16'h001b) begin
      n_fail++; $display("FAIL reuse_busy got %0d/%h exp 4/001b", o_outst, o_busy); end
  endtask

  task automatic test_stall();
    do_reset();
    o_r = 1'b0; i_v = 1'b1; i_clid = 4'd7;
    step();
    i_clid = 4'd8;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({o_v, o_clid, o_tag, i_r} !== {1'b1, 4'd7, 2'd0, 1'b0}) begin
        n_fail++; $display("FAIL stall[%0d] got %b/%0d/%0d/%b exp 1/7/0/0", c, o_v, o_clid, o_tag, i_r); end
      step();
    end
    o_r = 1'b1;
    #1;
    n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b exp 1", i_r); end
    step();
    i_v = 1'b0;
    n_checks++; if ({o_v, o_clid, o_tag} !== {1'b1, 4'd8, 2'd1}) begin
      n_fail++; $display("FAIL b2b got %b/%0d/%0d exp 1/8/1", o_v, o_clid, o_tag); end
    step();
    n_checks++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL drain got %b exp 0", o_v); end
  endtask

  task automatic test_err();
    do_reset();
    i_rsp_v = 1'b1; i_rsp_tag = 2'd3;
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b0 || o_err !== 1'b1 || o_outst !== 3'd0) begin
      n_fail++; $display("FAIL err got done=%b err=%b outst=%0d exp 0/1/0", o_done_v, o_err, o_outst); end
    step(); step();
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", o_err); end
  endtask

  task automatic test_dup();
    do_reset();
    o_r = 1'b1; i_v = 1'b1; i_clid = 4'd9;
    step();
    #1;
    n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL dup_i_r got %b exp 1", i_r); end
    step();
    i_v = 1'b0;
`ifdef L2_REQ_SCHED_DUP_FILTER_EN
    n_checks++; if (o_v !== 1'b0 || o_outst !== 3'd1) begin
      n_fail++; $display("FAIL dup_merge got v=%b outst=%0d exp 0/1", o_v, o_outst); end
`else
    n_checks++; if ({o_v, o_clid, o_tag} !== {1'b1, 4'd9, 2'd1} || o_outst !== 3'd2) begin
      n_fail++; $display("FAIL dup_alloc got %b/%0d/%0d outst=%0d exp 1/9/1/2",
                         o_v, o_clid, o_tag, o_outst); end
`endif
    i_rsp_v = 1'b1; i_rsp_tag = 2'd0;
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b1 || o_done_clid !== 4'd9) begin
      n_fail++; $display("FAIL dup_done0 got %b/%0d exp 1/9", o_done_v, o_done_clid); end
`ifdef L2_REQ_SCHED_DUP_FILTER_EN
    step();
    n_checks++; if (o_done_v !== 1'b0 || o_outst !== 3'd0 || o_busy !== 16'h0) begin
      n_fail++; $display("FAIL dup_single got %b/%0d/%h exp 0/0/0", o_done_v, o_outst, o_busy); end
`else
    n_checks++; if (o_busy !== 16'h0200) begin
      n_fail++; $display("FAIL dup_busy got %h exp 0200", o_busy); end
    i_rsp_v = 1'b1; i_rsp_tag = 2'd1;
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b1 || o_done_clid !== 4'd9 || o_outst !== 3'd0) begin
      n_fail++; $display("FAIL dup_done1 got %b/%0d/%0d exp 1/9/0", o_done_v, o_done_clid, o_outst); end
`endif
  endtask

  task automatic test_same_cycle();
    do_reset();
    o_r = 1'b1; i_v = 1'b1; i_clid = 4'd3;
    step();
    i_clid = 4'd6;
    step();
    i_rsp_v = 1'b1; i_rsp_tag = 2'd1;
    #1;
    n_checks++; if (i_r !== 1'b0) begin n_fail++; $display("FAIL same_i_r got %b exp 0", i_r); end
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b1 || o_done_clid !== 4'd6 || o_busy !== 16'h0008) begin
      n_fail++; $display("FAIL same_done got %b/%0d/%h exp 1/6/0008", o_done_v, o_done_clid, o_busy); end
    #1;
    n_checks++; if (i_r !== 1'b1) begin n_fail++; $display("FAIL same_next_i_r got %b exp 1", i_r); end
    step();
    i_v = 1'b0;
    n_checks++; if ({o_v, o_clid, o_tag} !== {1'b1, 4'd6, 2'd1} || o_outst !== 3'd2) begin
      n_fail++; $display("FAIL same_realloc got %b/%0d/%0d/%0d exp 1/6/1/2", o_v, o_clid, o_tag, o_outst); end
  endtask

  task automatic test_reset_mid();
    // Slots 0,1 hold ids 3,6 from the previous test; reset must drop them silently.
    do_reset();
    n_checks++; if (o_outst !== 3'd0 || o_busy !== 16'h0 || o_done_v !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got %0d/%h/%b exp 0/0/0", o_outst, o_busy, o_done_v); end
    i_rsp_v = 1'b1; i_rsp_tag = 2'd0;
    step();
    i_rsp_v = 1'b0;
    n_checks++; if (o_done_v !== 1'b0 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL mid_rsp got done=%b err=%b exp 0/1", o_done_v, o_err); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_err();
    test_dup();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
